fifo_rd_stream: RTL

// - Read-domain controller for the dual-clock BRAM FIFO; sits in i_rd_clk domain opposite the write-side pointer logic.
// - Owns read pointer, empty/level detection and BRAM read-port addressing; absorbs the 1-cycle registered BRAM read latency.
// - Presents FIFO contents as an AXI-Stream master with full throughput and correct backpressure via a 2-entry output buffer.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_rd_outbuf.sv | 73 +++++++
 rtl/fifo_rd_stream.sv | 74 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock BRAM FIFO: Gray/binary pointer conversion and default sizing.
package fifo_pkg;

    localparam int unsigned DEF_ADDR_BITS = 6;
    localparam int unsigned PTR_BITS      = DEF_ADDR_BITS + 1;

    // Both helpers work on a 32-bit container; narrower pointers are zero-extended by the caller.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_outbuf.sv
// Two-entry registered skid buffer between the BRAM read port and the AXI-Stream output.
module fifo_rd_outbuf #(
    parameter int unsigned DataW = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic [DataW-1:0] in_data_i,
    output logic [DataW-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [1:0]       count_o
);

    logic [DataW-1:0] slot0_q, slot0_d;
    logic [DataW-1:0] slot1_q, slot1_d;
    logic [1:0]       count_q, count_d;
    logic             valid_q;
    logic             pop;

    assign pop = valid_q & out_ready_i;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case ({in_valid_i, pop})
            2'b11: begin
                if (count_q == 2'd2) begin
                    slot0_d = slot1_q;
                    slot1_d = in_data_i;
                end else begin
                    slot0_d = in_data_i;
                end
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    slot0_d = slot1_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = in_data_i;
                end else begin
                    slot1_d = in_data_i;
                end
                count_d = count_q + 2'd1;
            end
            default: ;
        endcase
    end

    // Valid is kept as its own flop so the stream handshake is driven straight from a register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
            valid_q <= (count_d != 2'd0);
        end
    end

    assign out_data_o  = slot0_q;
    assign out_valid_o = valid_q;
    assign count_o     = count_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain controller of the dual-clock BRAM FIFO: read pointer, empty/level, BRAM read
// addressing and an AXI-Stream master that hides the one-cycle BRAM read latency.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [ADDR_BITS:0]    i_wr_ptr_gray,
    output logic [ADDR_BITS:0]    o_rd_ptr_gray,
    output logic                  o_mem_rd_en,
    output logic [ADDR_BITS-1:0]  o_mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  o_empty,
    output logic [ADDR_BITS:0]    o_rd_count
);

    localparam int unsigned PtrW = ADDR_BITS + 1;

    logic [PtrW-1:0] rd_bin_q, rd_bin_d;
    logic [PtrW-1:0] rd_gray_q;
    logic [PtrW-1:0] wr_bin;
    logic            inflight_q;
    logic [1:0]      buf_count;
    logic [1:0]      occ;
    logic            avail, pop, issue;

    assign wr_bin   = PtrW'(gray2bin(32'(i_wr_ptr_gray)));
    assign avail    = (rd_bin_q != wr_bin);
    assign pop      = m_axis_tvalid & m_axis_tready;
    assign occ      = buf_count + {1'b0, inflight_q};
    // A pop this cycle frees a slot for the word that lands two cycles from now.
    assign issue    = avail & ((occ < 2'd2) | pop);
    assign rd_bin_d = rd_bin_q + PtrW'(1);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rd_bin_q   <= '0;
            rd_gray_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                rd_bin_q  <= rd_bin_d;
                rd_gray_q <= PtrW'(bin2gray(32'(rd_bin_d)));
            end
        end
    end

    fifo_rd_outbuf #(
        .DataW (DATA_WIDTH)
    ) u_outbuf (
        .clk_i       (i_clk),
        .rst_ni      (i_reset_n),
        .in_valid_i  (inflight_q),
        .in_data_i   (i_mem_rd_data),
        .out_data_o  (m_axis_tdata),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready),
        .count_o     (buf_count)
    );

    assign o_rd_ptr_gray = rd_gray_q;
    assign o_mem_rd_en   = issue;
    assign o_mem_rd_addr = rd_bin_q[ADDR_BITS-1:0];
    assign o_empty       = ~avail;
    assign o_rd_count    = wr_bin - rd_bin_q;

endmodule
